inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  Writer side of the instruction-memory load interface used by the IF stage.
//  - Takes a byte stream from the UART receiver and packs each 4 bytes, MSB first, into one instruction word.
//  - Drives o_write, o_addr and o_instruction so IF writes the word while execution is disabled.
//  - Stops after the HALT word is written, and flags overflow or inter-byte timeout.
// PARAMETERS
//  INST_SZ      32          instruction width; must be a multiple of 8
//  MEM_SZ       10          log2 of instruction-memory depth in words
//  HALT_WORD    32'hFFFFFFFF  end-of-program marker; it is written, then loading stops
//  TIMEOUT_CYC  100000      max idle cycles between bytes of one partial word
// PORTS
//  i_clk          in   1        clock, rising edge
//  i_reset        in   1        asynchronous, active-low reset
//  i_start        in   1        1-cycle pulse: begin a load at word address 0
//  i_clear        in   1        1-cycle pulse: leave DONE or ERROR and go to IDLE
//  i_rx_data      in   8        received byte
//  i_rx_done      in   1        1-cycle strobe: i_rx_data is valid
//  o_write        out  1        1-cycle instruction-memory write strobe
//  o_addr         out  MEM_SZ   word address for o_write
//  o_instruction  out  INST_SZ  assembled word
//  o_loading      out  1        high in RECV and WRITE; the top level holds IF i_enable low while this is high
//  o_done         out  1        level: HALT word written
//  o_error        out  1        level: overflow or timeout
//  o_word_count   out  MEM_SZ+1 number of words written in this load
// BEHAVIOUR
//  Reset (i_reset=0, any time, asynchronous)
//   - State IDLE. All outputs 0. Byte index, address, timeout counter and shift register all 0.
//  FSM states: IDLE, RECV, WRITE, DONE, ERROR.
//  IDLE
//   - i_start -> RECV. Clears address, byte index, word count and timeout counter.
//   - i_rx_done in IDLE is ignored.
//  RECV
//   - On i_rx_done: shift register = {shift[INST_SZ-9:0], i_rx_data}. Byte index increments. Timeout counter clears.
//   - When the last byte arrives (index = INST_SZ/8-1): go to WRITE next cycle and reset the index.
//   - No i_rx_done and index != 0: timeout counter increments. Reaching TIMEOUT_CYC -> ERROR.
//   - No timeout while index = 0 (the host may pause between words).
//  WRITE (exactly 1 cycle)
//   - o_write=1, o_addr=current address, o_instruction=assembled word.
//   - Word count increments; address increments on exit.
//   - Exit: word == HALT_WORD -> DONE.
//     Else address == 2**MEM_SZ-1 -> ERROR (memory full, no HALT).
//     Else -> RECV.
//   - An i_rx_done arriving in WRITE is captured as byte 0 of the next word; no byte is dropped.
//  DONE, ERROR
//   - Outputs o_done or o_error held high.
//   - o_instruction and o_addr hold their last values.
//   - i_clear -> IDLE (clears o_done/o_error; word count holds until the next i_start).
//   - i_start without a prior i_clear is ignored.
//  Outputs and priority
//   - o_write is a registered output; it is never high outside WRITE.
//   - o_write is never asserted twice at the same address within one load.
//   - i_start during RECV or WRITE is ignored; there is no restart mid-load.
//   - Reset mid-load aborts the load; words already written remain in memory.
//   - Simultaneous i_clear and i_start in DONE: i_clear wins and the next state is IDLE.
// STRUCTURE
//  - Shared package/header: FSM state encodings, HALT_WORD default, BYTES_PER_WORD = INST_SZ/8.
//  - Single module.
//  - The timeout counter is the natural sub-module: loader_timeout (counter with clear, enable and terminal flag).
// TESTING
//  1. Reset low mid-RECV after 2 bytes -> all outputs 0, state IDLE; a new i_start then loads from o_addr=0.
//  2. i_start, then bytes 20 08 00 05, FF FF FF FF ->
//     o_write at addr 0 with 32'h20080005; o_write at addr 1 with 32'hFFFFFFFF;
//     o_done=1, o_word_count=2, o_loading=0.
//  3. i_start, bytes 12 34, then TIMEOUT_CYC idle cycles ->
//     o_error=1, no o_write; i_clear -> IDLE, o_error=0.
//  4. MEM_SZ=2, four non-HALT words ->
//     o_write at addrs 0..3, then o_error=1, o_word_count=4.
//  5. i_rx_done on the WRITE cycle with byte AA -> next written word has AA in bits [31:24].
//  6. Bytes sent in IDLE, and i_start pulsed during RECV -> bytes ignored, load not restarted, address unchanged.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// default HALT marker and the bytes-per-word helper.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam int unsigned INST_SZ_DEFAULT   = 32;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    function automatic int unsigned bytes_per_word(input int unsigned inst_sz);
        return inst_sz / 8;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter with clear and enable; o_terminal flags the cycle on
// which the count would reach LIMIT.
module loader_timeout #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_terminal = i_enable && !i_clear && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/inst_loader.sv
// Packs a UART byte stream (MSB first) into instruction words and writes
// them into instruction memory until the HALT word, overflow or timeout.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned          INST_SZ     = INST_SZ_DEFAULT,
    parameter int unsigned          MEM_SZ      = 10,
    parameter logic [INST_SZ-1:0]   HALT_WORD   = INST_SZ'(HALT_WORD_DEFAULT),
    parameter int unsigned          TIMEOUT_CYC = 100000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_clear,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_done,
    output logic               o_write,
    output logic [MEM_SZ-1:0]  o_addr,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_loading,
    output logic               o_done,
    output logic               o_error,
    output logic [MEM_SZ:0]    o_word_count,
    output logic [2:0]         o_state
);

    // Handshake: i_rx_done and o_write are single-cycle strobes with no
    // backpressure; data is valid only in the cycle its strobe is high.
    localparam int unsigned BPW = bytes_per_word(INST_SZ);
    localparam int unsigned IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IW-1:0]     LAST_IDX = IW'(BPW - 1);
    localparam logic [MEM_SZ-1:0] ADDR_MAX = '1;

    state_t              state_q, state_d;
    logic [INST_SZ-1:0]  shift_q, shift_d;
    logic [INST_SZ-1:0]  instr_q, instr_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [MEM_SZ-1:0]   addr_q, addr_d;
    logic [MEM_SZ:0]     count_q, count_d;
    logic                write_q, write_d;
    logic                tmo_clear, tmo_enable, tmo_terminal;

    // Timeout only runs while a word is partially received.
    assign tmo_enable = (state_q == S_RECV) && (idx_q != '0) && !i_rx_done;
    assign tmo_clear  = !tmo_enable;

    loader_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (tmo_clear),
        .i_enable   (tmo_enable),
        .o_terminal (tmo_terminal)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RECV;
            S_RECV: begin
                if (i_rx_done && (idx_q == LAST_IDX)) begin
                    state_d = S_WRITE;
                end else if (tmo_terminal) begin
                    state_d = S_ERROR;
                end
            end
            S_WRITE: begin
                if (instr_q == HALT_WORD) begin
                    state_d = S_DONE;
                end else if (addr_q == ADDR_MAX) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DONE, S_ERROR: if (i_clear) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        instr_d = instr_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        count_d = count_q;
        write_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            S_RECV: begin
                if (i_rx_done) begin
                    shift_d = INST_SZ'({shift_q, i_rx_data});
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        write_d = 1'b1;
                        instr_d = INST_SZ'({shift_q, i_rx_data});
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_WRITE: begin
                count_d = count_q + (MEM_SZ+1)'(1);
                // Address only advances when another word follows, so it
                // holds the last written address in DONE/ERROR.
                if (state_d == S_RECV) begin
                    addr_d = addr_q + MEM_SZ'(1);
                end
                if (i_rx_done) begin
                    shift_d = INST_SZ'({shift_q, i_rx_data});
                    idx_d   = idx_q + IW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
            instr_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            write_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            instr_q <= instr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        o_loading = (state_q == S_RECV) || (state_q == S_WRITE);
        o_done    = (state_q == S_DONE);
        o_error   = (state_q == S_ERROR);
    end

    assign o_write       = write_q;
    assign o_addr        = addr_q;
    assign o_instruction = instr_q;
    assign o_word_count  = count_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader with a word-level
// reference model and an expected-write scoreboard.
module tb_inst_loader;

    localparam int          INST_SZ = 32;
    localparam int          MEM_SZ  = 2;
    localparam int          TMO     = 40;
    localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               clr;
    logic [7:0]         rx_data;
    logic               rx_done;
    logic               o_write;
    logic [MEM_SZ-1:0]  o_addr;
    logic [INST_SZ-1:0] o_instruction;
    logic               o_loading;
    logic               o_done;
    logic               o_error;
    logic [MEM_SZ:0]    o_word_count;
    logic [2:0]         o_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [MEM_SZ+INST_SZ-1:0] exp_q[$];
    logic [7:0]                stim_q[$];

    inst_loader #(
        .INST_SZ     (INST_SZ),
        .MEM_SZ      (MEM_SZ),
        .HALT_WORD   (HALT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_clear       (clr),
        .i_rx_data     (rx_data),
        .i_rx_done     (rx_done),
        .o_write       (o_write),
        .o_addr        (o_addr),
        .o_instruction (o_instruction),
        .o_loading     (o_loading),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_word_count  (o_word_count),
        .o_state       (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the head of exp_q.
    always @(negedge clk) begin : write_monitor
        logic [MEM_SZ+INST_SZ-1:0] e;
        if (rst_n && o_write) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write got addr=%0d data=%h, expected no write", o_addr, o_instruction);
            end else begin
                e = exp_q.pop_front();
                if ({o_addr, o_instruction} !== e) begin
                    n_fail++;
                    $display("FAIL write_data got addr=%0d data=%h, expected addr=%0d data=%h",
                             o_addr, o_instruction, e[INST_SZ +: MEM_SZ], e[INST_SZ-1:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) stim_q.push_back(w[8*k +: 8]);
    endtask

    // Reference model: words are consecutive byte quads; the load ends at
    // HALT (done) or after filling the last address without HALT (error).
    task automatic run_model(output logic done, output logic err, output int cnt);
        logic [31:0] w;
        done = 1'b0;
        err  = 1'b0;
        cnt  = 0;
        for (int i = 0; i + 3 < stim_q.size() && !done && !err; i += 4) begin
            w = {stim_q[i], stim_q[i+1], stim_q[i+2], stim_q[i+3]};
            exp_q.push_back({MEM_SZ'(cnt), w});
            cnt++;
            if (w == HALT) done = 1'b1;
            else if (cnt == (1 << MEM_SZ)) err = 1'b1;
        end
    endtask

    task automatic drive_stream(input int gap_max);
        for (int i = 0; i < stim_q.size(); i++) send_byte(stim_q[i], $urandom_range(0, gap_max));
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clr = 1'b0; rx_data = 8'h00; rx_done = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({o_write, o_addr, o_instruction, o_loading, o_done, o_error, o_word_count, o_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got write=%b addr=%0d instr=%h load=%b done=%b err=%b cnt=%0d st=%0d, expected all 0",
                     o_write, o_addr, o_instruction, o_loading, o_done, o_error, o_word_count, o_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_recv();
        logic d, e; int c;
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_write, o_addr, o_instruction, o_loading, o_done, o_error, o_word_count, o_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_recv got load=%b addr=%0d st=%0d cnt=%0d, expected all 0",
                     o_loading, o_addr, o_state, o_word_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stim_q.delete();
        push_word(32'h0102_0304);
        push_word(HALT);
        run_model(d, e, c);
        pulse_start();
        drive_stream(2);
        n_tests++;
        if (o_done !== d || o_word_count !== (MEM_SZ+1)'(c) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reload_after_reset got done=%b cnt=%0d pending=%0d, expected done=%b cnt=%0d pending=0",
                     o_done, o_word_count, exp_q.size(), d, c);
        end
        pulse_clear();
    endtask

    task automatic test_basic_load();
        logic d, e; int c;
        stim_q.delete();
        push_word(32'h2008_0005);
        push_word(HALT);
        run_model(d, e, c);
        pulse_start();
        drive_stream(0);
        n_tests++;
        if (o_done !== 1'b1 || o_error !== 1'b0 || o_loading !== 1'b0 || o_word_count !== 3'd2) begin
            n_fail++;
            $display("FAIL basic_status got done=%b err=%b load=%b cnt=%0d, expected 1 0 0 2",
                     o_done, o_error, o_loading, o_word_count);
        end
        n_tests++;
        if (o_addr !== 2'd1 || o_instruction !== HALT || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_hold got addr=%0d instr=%h pending=%0d, expected 1 ffffffff 0",
                     o_addr, o_instruction, exp_q.size());
        end
        pulse_start();
        n_tests++;
        if (o_done !== 1'b1 || o_state !== 3'd3) begin
            n_fail++;
            $display("FAIL start_in_done got done=%b st=%0d, expected done=1 st=3", o_done, o_state);
        end
        pulse_clear();
        n_tests++;
        if (o_done !== 1'b0 || o_state !== 3'd0 || o_word_count !== 3'd2) begin
            n_fail++;
            $display("FAIL clear_done got done=%b st=%0d cnt=%0d, expected 0 0 2", o_done, o_state, o_word_count);
        end
    endtask

    task automatic test_timeout();
        pulse_start();
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        repeat (TMO - 1) @(negedge clk);
        n_tests++;
        if (o_error !== 1'b0 || o_loading !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early got err=%b load=%b after %0d idle cycles, expected err=0 load=1",
                     o_error, o_loading, TMO - 1);
        end
        @(negedge clk);
        n_tests++;
        if (o_error !== 1'b1 || o_loading !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_hit got err=%b load=%b after %0d idle cycles, expected err=1 load=0",
                     o_error, o_loading, TMO);
        end
        pulse_clear();
        n_tests++;
        if (o_error !== 1'b0 || o_state !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_clear got err=%b st=%0d, expected err=0 st=0", o_error, o_state);
        end
    endtask

    task automatic test_mem_full();
        logic d, e; int c;
        stim_q.delete();
        for (int i = 0; i < 4; i++) push_word($urandom() & 32'h7FFF_FFFF);
        run_model(d, e, c);
        pulse_start();
        drive_stream(1);
        n_tests++;
        if (o_error !== 1'b1 || o_done !== 1'b0 || o_word_count !== 3'd4 || o_addr !== 2'd3) begin
            n_fail++;
            $display("FAIL mem_full got err=%b done=%b cnt=%0d addr=%0d, expected 1 0 4 3",
                     o_error, o_done, o_word_count, o_addr);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mem_full_writes got %0d missing writes, expected 0", exp_q.size());
        end
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        logic d, e; int c;
        stim_q.delete();
        push_word(32'hDEAD_BEEF);
        push_word(32'hAA55_6677);
        push_word(HALT);
        run_model(d, e, c);
        pulse_start();
        drive_stream(0);
        n_tests++;
        if (o_done !== 1'b1 || o_word_count !== 3'd3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back got done=%b cnt=%0d pending=%0d, expected 1 3 0",
                     o_done, o_word_count, exp_q.size());
        end
        pulse_clear();
    endtask

    task automatic test_ignore();
        logic d, e; int c;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom()), 0);
        n_tests++;
        if (o_state !== 3'd0 || o_loading !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_bytes got st=%0d load=%b, expected st=0 load=0", o_state, o_loading);
        end
        stim_q.delete();
        push_word(32'h0BAD_F00D);
        push_word(HALT);
        run_model(d, e, c);
        pulse_start();
        send_byte(stim_q[0], 0);
        send_byte(stim_q[1], 0);
        pulse_start();
        n_tests++;
        if (o_addr !== 2'd0 || o_loading !== 1'b1 || o_state !== 3'd1) begin
            n_fail++;
            $display("FAIL start_mid_recv got addr=%0d load=%b st=%0d, expected 0 1 1", o_addr, o_loading, o_state);
        end
        for (int i = 2; i < stim_q.size(); i++) send_byte(stim_q[i], 1);
        repeat (3) @(negedge clk);
        n_tests++;
        if (o_done !== d || o_word_count !== (MEM_SZ+1)'(c) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ignore_load got done=%b cnt=%0d pending=%0d, expected %b %0d 0",
                     o_done, o_word_count, exp_q.size(), d, c);
        end
        start = 1'b1;
        clr   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clr   = 1'b0;
        n_tests++;
        if (o_state !== 3'd0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_beats_start got st=%0d done=%b, expected st=0 done=0", o_state, o_done);
        end
    endtask

    task automatic test_random();
        logic d, e; int c;
        logic [31:0] w;
        for (int it = 0; it < 25; it++) begin
            stim_q.delete();
            for (int i = 0; i < 4; i++) begin
                w = ($urandom_range(0, 3) == 0) ? HALT : $urandom();
                push_word(w);
                if (w == HALT) break;
            end
            run_model(d, e, c);
            pulse_start();
            drive_stream(3);
            n_tests++;
            if (o_done !== d || o_error !== e || o_word_count !== (MEM_SZ+1)'(c) || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL random_%0d got done=%b err=%b cnt=%0d pending=%0d, expected %b %b %0d 0",
                         it, o_done, o_error, o_word_count, exp_q.size(), d, e, c);
            end
            pulse_clear();
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_recv();
        test_basic_load();
        test_timeout();
        test_mem_full();
        test_back_to_back();
        test_ignore();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
